// File: rtl/mcu_isa_pkg.sv
// Shared ISA definitions for the fetch/dispatch stage: opcodes, unit indices,
// fault codes and the fetch FSM state encoding.
package mcu_isa_pkg;

   localparam logic [3:0] OP_ALU    = 4'b0000;
   localparam logic [3:0] OP_ALUI   = 4'b0001;
   localparam logic [3:0] OP_LOAD   = 4'b0010;
   localparam logic [3:0] OP_STORE  = 4'b0011;
   localparam logic [3:0] OP_MOVE   = 4'b0100;
   localparam logic [3:0] OP_BRANCH = 4'b0101;
   localparam logic [3:0] OP_HALT   = 4'b1111;

   localparam int UNIT_ALU    = 0;
   localparam int UNIT_ALUI   = 1;
   localparam int UNIT_LOAD   = 2;
   localparam int UNIT_STORE  = 3;
   localparam int UNIT_MOVE   = 4;
   localparam int UNIT_BRANCH = 5;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      FC_NONE         = 2'b00,
      FC_MEM_TIMEOUT  = 2'b01,
      FC_ILLEGAL_OP   = 2'b10,
      FC_EXEC_TIMEOUT = 2'b11
   } fault_code_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_MEM,
      S_DECODE,
      S_DISPATCH,
      S_EXECUTE,
      S_HALT,
      S_FAULT
   } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: one-hot execution unit select, legality and HALT detect.
module instr_decoder
   import mcu_isa_pkg::*;
#(
   parameter int N_UNITS = 6
)(
   input  logic [3:0]         opcode,
   output logic [N_UNITS-1:0] sel_onehot,
   output logic               legal,
   output logic               is_halt
);

   always_comb begin
      sel_onehot = '0;
      // Opcodes map directly onto unit indices; units beyond N_UNITS stay unselected.
      for (int i = 0; i < N_UNITS; i++) begin
         if (int'(opcode) <= UNIT_BRANCH && int'(opcode) == i)
            sel_onehot[i] = 1'b1;
      end
      legal   = |sel_onehot;
      is_halt = (opcode == OP_HALT);
   end

endmodule

// File: rtl/instr_fetch_dispatch.sv
// Fetch/dispatch stage: reads an instruction word, decodes it, starts the matching
// execution unit and waits for its done before fetching the next word.
module instr_fetch_dispatch
   import mcu_isa_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int N_UNITS      = 6,
   parameter int MEM_TIMEOUT  = 255,
   parameter int EXEC_TIMEOUT = 255
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               mem_ready,
   input  logic [DATA_W-1:0]  mem_data,
   input  logic [N_UNITS-1:0] done,
   output logic               PC_out,
   output logic               mem_rd,
   output logic [DATA_W-1:0]  instr,
   output logic [N_UNITS-1:0] start,
   output logic               busy,
   output logic               halted,
   output logic               fault,
   output logic [1:0]         fault_code
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [N_UNITS-1:0] sel_q;
   logic [N_UNITS-1:0] dec_sel;
   logic               dec_legal, dec_halt;
   logic               done_lat_q;
   logic               done_hit;
   logic               mem_to, exec_to;
   logic [1:0]         fault_code_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   instr_decoder #(.N_UNITS(N_UNITS)) u_dec (
      .opcode     (instr[15:12]),
      .sel_onehot (dec_sel),
      .legal      (dec_legal),
      .is_halt    (dec_halt)
   );

   // A done that arrives together with start is remembered for the first EXECUTE cycle.
   assign done_hit = (|(done & sel_q)) | done_lat_q;
   assign mem_to   = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
   assign exec_to  = (cnt_q == CNT_W'(EXEC_TIMEOUT - 1));

   assign PC_out = (state_q == S_FETCH) || (state_q == S_WAIT_MEM);
   assign mem_rd = (state_q == S_FETCH) || (state_q == S_WAIT_MEM);
   assign busy   = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_FAULT));

   always_comb begin
      state_d      = state_q;
      fault_code_d = fault_code;
      case (state_q)
         S_IDLE:     if (run) state_d = S_FETCH;
         S_FETCH:    state_d = S_WAIT_MEM;
         S_WAIT_MEM: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (mem_to) begin
               state_d      = S_FAULT;
               fault_code_d = FC_MEM_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (dec_halt) begin
               state_d = S_HALT;
            end else if (dec_legal) begin
               state_d = S_DISPATCH;
            end else begin
               state_d      = S_FAULT;
               fault_code_d = FC_ILLEGAL_OP;
            end
         end
         S_DISPATCH: state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (done_hit) begin
               state_d = S_FETCH;
            end else if (exec_to) begin
               state_d      = S_FAULT;
               fault_code_d = FC_EXEC_TIMEOUT;
            end
         end
         default:    state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         instr      <= '0;
         sel_q      <= '0;
         done_lat_q <= 1'b0;
         start      <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= (state_d != state_q) ? '0 : sat_inc(cnt_q);
         if (state_q == S_WAIT_MEM && mem_ready)
            instr <= mem_data;
         if (state_q == S_DECODE)
            sel_q <= dec_sel;
         start      <= (state_d == S_DISPATCH) ? dec_sel : '0;
         done_lat_q <= (state_q == S_DISPATCH) && (|(done & sel_q));
         halted     <= halted | (state_d == S_HALT);
         fault      <= fault | (state_d == S_FAULT);
         fault_code <= fault_code_d;
      end
   end

endmodule
